load_store_unit: RTL and testbench

- Initiator for the single-port data memory: accepts one load/store request at a time from the datapath.
- Translates the byte address into the memory's word index and drives mem_write / mem_address / mem_write_data; samples mem_read_data, which the memory returns combinationally.
- Adds byte/halfword access, sign/zero extension, read-modify-write for sub-word stores, and alignment/range checking.

---
 rtl/load_store_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-request initiator for a single-port word memory.
// Supports byte/halfword/word loads and stores, sign/zero extension of loads,
// read-modify-write for sub-word stores and alignment/range error detection.
// Optional statistics counters are built when LSU_STATS_EN is defined;
// otherwise the stat_* ports are tied to zero.
module load_store_unit #(
  parameter int WORD_INDEX_BITS = 8,
  parameter int STAT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_write,
  output logic [31:0]           mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output logic [STAT_WIDTH-1:0] stat_loads,
  output logic [STAT_WIDTH-1:0] stat_stores,
  output logic [STAT_WIDTH-1:0] stat_errors
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic        w_accept;
  logic        w_range_err;
  logic        w_align_err;
  logic        w_err;

  // Latched request fields (no reset needed: only read after acceptance)
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_unsigned;
  logic [31:0] r_wdata;

  // Registered outputs
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;

  // Extract the addressed lane(s) of a word and extend to 32 bits.
  function automatic logic [31:0] f_extend(input logic [31:0] word,
                                           input logic [1:0]  size,
                                           input logic [1:0]  lane,
                                           input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane(s) of the old word with new store data.
  function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                          input logic [31:0] wdata,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (size)
      SZ_BYTE: res[{lane, 3'b000} +: 8]    = wdata[7:0];
      SZ_HALF: res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_range_err = (req_addr >> (WORD_INDEX_BITS + 2)) != 32'd0;

  // Alignment / size legality of the incoming request
  always_comb begin
    w_align_err = 1'b0;
    case (req_size)
      SZ_BYTE: w_align_err = 1'b0;
      SZ_HALF: w_align_err = req_addr[0];
      SZ_WORD: w_align_err = (req_addr[1:0] != 2'b00);
      default: w_align_err = 1'b1;
    endcase
  end

  assign w_err = w_align_err || w_range_err;

  // Next-state decode of the access sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)                   w_state_nxt = S_RESP;
          else if (!req_write)         w_state_nxt = S_LOAD;
          else if (req_size == SZ_WORD) w_state_nxt = S_WRITE;
          else                         w_state_nxt = S_READ;
        end
      end
      S_LOAD:  w_state_nxt = S_RESP;
      S_READ:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; async reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture request fields at acceptance
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_size     <= req_size;
      r_lane     <= req_addr[1:0];
      r_unsigned <= req_unsigned;
      r_wdata    <= req_wdata;
    end
  end

  // Word index held from acceptance until the next acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_mem_address <= 32'd0;
    else if (w_accept) r_mem_address <= {2'b00, req_addr[31:2]};
  end

  // Write data: full word at acceptance, or merged old word in READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_wdata <= 32'd0;
    end else if (w_accept && !w_err && req_write && (req_size == SZ_WORD)) begin
      r_mem_wdata <= req_wdata;
    end else if (r_state == S_READ) begin
      r_mem_wdata <= f_merge(mem_read_data, r_wdata, r_size, r_lane);
    end
  end

  // Response data/error, held until the next response is produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_rdata <= 32'd0;
      r_resp_error <= 1'b0;
    end else if (w_accept && w_err) begin
      r_resp_rdata <= 32'd0;
      r_resp_error <= 1'b1;
    end else if (r_state == S_LOAD) begin
      r_resp_rdata <= f_extend(mem_read_data, r_size, r_lane, r_unsigned);
      r_resp_error <= 1'b0;
    end else if (r_state == S_WRITE) begin
      r_resp_rdata <= 32'd0;
      r_resp_error <= 1'b0;
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = (r_state == S_RESP);
  assign resp_rdata     = r_resp_rdata;
  assign resp_error     = r_resp_error;
  // Decoded from state so it drops the instant reset clears the state
  assign mem_write      = (r_state == S_WRITE);
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_wdata;

`ifdef LSU_STATS_EN
  logic                  r_write;
  logic [STAT_WIDTH-1:0] r_stat_loads;
  logic [STAT_WIDTH-1:0] r_stat_stores;
  logic [STAT_WIDTH-1:0] r_stat_errors;

  // Remember the direction so the response can be classified
  always_ff @(posedge clk) begin
    if (w_accept) r_write <= req_write;
  end

  // Saturating per-response-type counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_loads  <= '0;
      r_stat_stores <= '0;
      r_stat_errors <= '0;
    end else if (r_state == S_RESP) begin
      if (r_resp_error) begin
        if (r_stat_errors != '1) r_stat_errors <= r_stat_errors + 1'b1;
      end else if (r_write) begin
        if (r_stat_stores != '1) r_stat_stores <= r_stat_stores + 1'b1;
      end else begin
        if (r_stat_loads != '1)  r_stat_loads  <= r_stat_loads + 1'b1;
      end
    end
  end

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errors = r_stat_errors;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errors = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized requests
// checked against a byte-addressed reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errors;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_INDEX_BITS(8), .STAT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errors(stat_errors)
  );

  // Environment: the data memory itself (combinational read, sync write)
  logic [31:0] tb_mem [0:255];
  assign mem_read_data = tb_mem[mem_address[7:0]];
  always @(posedge clk) if (mem_write) tb_mem[mem_address[7:0]] <= mem_write_data;

  // Observe write strobes
  int          wr_cnt = 0;
  logic [31:0] wr_addr = 32'd0;
  always @(negedge clk) if (mem_write) begin wr_cnt++; wr_addr = mem_address; end

  // Reference model: plain byte array, little-endian
  logic [7:0] ref_bytes [0:1023];
  int ref_loads = 0, ref_stores = 0, ref_errors = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    tb_mem[idx] = val;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4 + i] = val[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
  endfunction

  function automatic bit ref_is_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (a > 32'h3FF);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(a[9:0]) + i]) << (8*i));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_bytes[int'(a[9:0]) + i] = wd[8*i +: 8];
  endtask

  // One complete transaction; returns at the negedge of the response cycle.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit hold, input string tag);
    bit          err;
    int          lat;
    int          n;
    logic [31:0] exp;
    err = ref_is_err(sz, a);
    lat = err ? 1 : ((!w || sz == 2'b10) ? 2 : 3);
    exp = (err || w) ? 32'd0 : ref_load(a, sz, u);
    @(negedge clk);
    wr_cnt = 0;
    check({tag, "/ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    n = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (resp_valid) begin n = c; break; end
      check({tag, "/busy_ready"}, req_ready, 1'b0);
    end
    if (!hold) req_valid = 1'b0;
    check({tag, "/latency"}, n, lat);
    check({tag, "/resp_ready"}, req_ready, 1'b0);
    check({tag, "/rdata"}, resp_rdata, exp);
    check({tag, "/error"}, resp_error, err);
    check({tag, "/wr_cnt"}, wr_cnt, (w && !err) ? 1 : 0);
    if (w && !err) begin
      ref_store(a, sz, wd);
      check({tag, "/wr_addr"}, wr_addr, {2'b00, a[31:2]});
      check({tag, "/mem_word"}, tb_mem[a[9:2]], ref_word(int'(a[9:2])));
    end
    if (err) ref_errors++;
    else if (w) ref_stores++;
    else ref_loads++;
  endtask

  task automatic check_stats(input string tag);
`ifdef LSU_STATS_EN
    check({tag, "/stat_loads"},  stat_loads,  ref_loads);
    check({tag, "/stat_stores"}, stat_stores, ref_stores);
    check({tag, "/stat_errors"}, stat_errors, ref_errors);
`else
    check({tag, "/stat_loads0"},  stat_loads,  16'd0);
    check({tag, "/stat_stores0"}, stat_stores, 16'd0);
    check({tag, "/stat_errors0"}, stat_errors, 16'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) preload(i, $urandom);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/resp_valid", resp_valid, 1'b0);
    check("rst/mem_write", mem_write, 1'b0);
    check("rst/mem_address", mem_address, 32'd0);
    check("rst/mem_write_data", mem_write_data, 32'd0);
    check("rst/resp_rdata", resp_rdata, 32'd0);
    check("rst/resp_error", resp_error, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/req_ready", req_ready, 1'b1);
    check("rst/addr_after", mem_address, 32'd0);
    check_stats("rst");

    // Word store then word load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "wst");
    check("wst/mem4", tb_mem[4], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, "wld");
    check("wld/const", resp_rdata, 32'hDEADBEEF);

    // Byte store merge
    preload(4, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 1'b0, "bst");
    check("bst/const", tb_mem[4], 32'h1122AA44);

    // Extension
    preload(8, 32'h8000F0FF);
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, "lb_s");
    check("lb_s/const", resp_rdata, 32'hFFFFFFFF);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, "lh_u");
    check("lh_u/const", resp_rdata, 32'h00008000);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0, "lh_s");
    check("lh_s/const", resp_rdata, 32'hFFFF8000);

    // Error requests
    do_req(1'b0, 2'b10, 1'b0, 32'h13,  32'h0, 1'b0, "err_mis_w");
    do_req(1'b1, 2'b01, 1'b0, 32'h01,  32'h1234, 1'b0, "err_mis_h");
    do_req(1'b0, 2'b11, 1'b0, 32'h40,  32'h0, 1'b0, "err_size");
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0, "err_range");

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a  = 32'($urandom_range(0, 1023));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 9) == 0) a = a | 32'h0001_0000;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             1'b0, $sformatf("rnd%0d", k));
    end
    check_stats("rnd");

    // Async reset during WRITE of a word store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    check("arst/mw_before", mem_write, 1'b1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("arst/mw_drop", mem_write, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_loads = 0; ref_stores = 0; ref_errors = 0;
    check("arst/mem_unchanged", tb_mem[12], ref_word(12));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("arst/ready", req_ready, 1'b1);
      check("arst/no_resp", resp_valid, 1'b0);
    end
    check_stats("arst");

    // Back-to-back with req_valid held continuously
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, "b2b_ld0");
    do_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h5A, 1'b1, "b2b_st0");
    do_req(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 1'b1, "b2b_ld1");
    do_req(1'b1, 2'b10, 1'b0, 32'h44, 32'h01020304, 1'b1, "b2b_st1");
    do_req(1'b0, 2'b01, 1'b0, 32'h46, 32'h0, 1'b1, "b2b_ld2");
    do_req(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1'b0, "b2b_err");
    @(negedge clk);
    check_stats("b2b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
